vga_pattern_gen: RTL
====================

# vga_pattern_gen

Parametrised VGA timing and test-pattern generator, the successor to the fixed 1920×1080@60 controller. All horizontal and vertical timings, sync polarities and colour depth are parameters. It adds a data-enable output, pixel coordinates, a frame-start strobe and an internal key debouncer. Pattern-mode changes take effect only at frame boundaries, so a frame is never torn. It sits directly behind the pixel-clock PLL and drives the VGA DAC pins.

## Interface
- H_ACTIVE, 1920, visible pixels per line
- H_FP / H_SYNC / H_BP, 88 / 44 / 148, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 1080, visible lines per frame
- V_FP / V_SYNC / V_BP, 4 / 5 / 36, vertical front porch / sync / back porch in lines
- HS_POL / VS_POL, 1 / 1, active level of VGA_HS / VGA_VS
- CW, 1, bits per colour channel
- CHK_LOG2, 5, checkerboard square size is 2^CHK_LOG2 pixels
- DEB_CYCLES, 16, cycles of stability the debouncer requires
- CLK  in  1  pixel clock; all logic is on its rising edge
- RESET  in  1  asynchronous, active-high
- KEYA  in  1  raw mode key, active-low (pressed = 0), asynchronous to CLK
- VGA_HS / VGA_VS  out  1  horizontal / vertical sync, polarity set by HS_POL / VS_POL
- VGA_DE  out  1  high while in the active area
- VGA_R / VGA_G / VGA_B  out  CW  colour channels
- PIX_X  out  $clog2(H_TOTAL)  horizontal counter value, registered
- PIX_Y  out  $clog2(V_TOTAL)  vertical counter value, registered
- FRAME_START  out  1  one-cycle pulse when the outputs show h=0, v=0
- MODE  out  2  currently applied pattern mode

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way. These are localparams.
- h counts 0..H_TOTAL-1 and wraps to 0. v increments when h wraps and itself wraps at V_TOTAL-1.
- HS is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- DE = (h < H_ACTIVE) && (v < V_ACTIVE). RGB is forced to 0 whenever DE is 0.
- Colour code c[2:0] maps to R=c[2], G=c[1], B=c[0]. Each bit is replicated across all CW bits of its channel.
- Bar width BW = H_ACTIVE/8 and bar height BH = V_ACTIVE/8, both integer division.
- Pattern modes:
  - Mode 0, vertical bars: c = 7 − h/BW for h < 8·BW, otherwise 0.
  - Mode 1, horizontal bars: c = 7 − v/BH for v < 8·BH, otherwise 0.
  - Mode 2: c = mode0 XOR mode1.
  - Mode 3, checkerboard: c = {3{h[CHK_LOG2] ^ v[CHK_LOG2]}}.
- Bar indices are computed with boundary comparators, not dividers.
- Debouncer:
  - KEYA passes through a 2-flop synchroniser.
  - The synchronised level must stay low for DEB_CYCLES consecutive cycles to produce a single press pulse.
  - It must then stay high for DEB_CYCLES before another press is accepted. Glitches shorter than DEB_CYCLES are ignored.
- Mode update:
  - A press sets `pending`.
  - On the cycle where h=H_TOTAL-1 and v=V_TOTAL-1, a set `pending` advances MODE (3 wraps to 0) and clears itself.
  - Any further presses within the same frame are dropped, so MODE advances at most once per frame.
  - If a press and the frame boundary fall on the same cycle, the press is applied at that boundary.

## Timing
- All outputs are registered. The outputs reflect counter state (h,v) exactly 1 cycle later, and sync, DE, RGB and PIX_X/PIX_Y stay mutually aligned.
- Reset values: h=v=0, MODE=0, pending=0, debouncer idle (released).
- Outputs during reset: VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_DE=0, RGB=0, PIX_X=PIX_Y=0, FRAME_START=0.
- First FRAME_START: the first cycle of the outputs after RESET deasserts shows h=0, v=0 with FRAME_START=1.
- A new MODE becomes visible on outputs starting with the FRAME_START cycle of the next frame.
- Press-to-pending latency: 2 synchroniser cycles plus DEB_CYCLES.
- Reset asserted mid-frame clears everything immediately and asynchronously, including any pending press.

## Structure
- Package `vga_timing_pkg`:
  - timing constant sets for 1920×1080@60 (values above) and 640×480@60 (640/16/96/48, 480/10/2/33, negative polarity);
  - the mode encoding constants MODE_VBAR, MODE_HBAR, MODE_XOR, MODE_CHECK.
- Sub-module `key_debounce`: synchroniser plus debounce counter; one-cycle press output; parameter DEB_CYCLES.

## Test plan
Small sim config unless noted: H 16/2/2/4, V 8/1/1/2, CW=2, DEB_CYCLES=4, CHK_LOG2=1.
1. Release reset, run 2 frames:
   - H_TOTAL=24 and V_TOTAL=12.
   - HS is active (high) for h=18..19 and VS for v=9.
   - DE is high for 16×8 pixels per frame.
   - FRAME_START pulses once every 288 cycles.
2. Mode 0, line 0:
   - Pixels h=0,1 give RGB=(3,3,3).
   - h=2,3 give (3,3,0).
   - h=14,15 give (0,0,0).
   - RGB is 0 during blanking.
3. KEYA low for 2 cycles (glitch) -> MODE unchanged. KEYA low for 10 cycles mid-frame -> MODE stays 0 until the next FRAME_START, then reads 1.
4. Two valid presses within one frame -> MODE advances by exactly 1. Four frames each containing one press starting from MODE 3 -> MODE reads 0, 1, 2, 3.
5. Assert RESET at h=7, v=3:
   - outputs go to their reset values without waiting for a clock edge;
   - after release the sequence restarts at h=0, v=0 with MODE=0.
6. Default 1080p parameters, CW=1: HS high for 44 cycles per 2200-cycle line, and VS high for 5 lines.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Timing presets, pattern-mode encoding and colour helpers shared by the VGA pattern generator.
// Presets are plain integers so they can seed module parameters directly.
package vga_timing_pkg;

  // 1920x1080@60, positive sync polarity
  localparam int T1080_H_ACTIVE = 1920;
  localparam int T1080_H_FP     = 88;
  localparam int T1080_H_SYNC   = 44;
  localparam int T1080_H_BP     = 148;
  localparam int T1080_V_ACTIVE = 1080;
  localparam int T1080_V_FP     = 4;
  localparam int T1080_V_SYNC   = 5;
  localparam int T1080_V_BP     = 36;
  localparam bit T1080_HS_POL   = 1'b1;
  localparam bit T1080_VS_POL   = 1'b1;

  // 640x480@60, negative sync polarity
  localparam int T480_H_ACTIVE = 640;
  localparam int T480_H_FP     = 16;
  localparam int T480_H_SYNC   = 96;
  localparam int T480_H_BP     = 48;
  localparam int T480_V_ACTIVE = 480;
  localparam int T480_V_FP     = 10;
  localparam int T480_V_SYNC   = 2;
  localparam int T480_V_BP     = 33;
  localparam bit T480_HS_POL   = 1'b0;
  localparam bit T480_VS_POL   = 1'b0;

  typedef enum logic [1:0] {
    MODE_VBAR  = 2'd0,
    MODE_HBAR  = 2'd1,
    MODE_XOR   = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic {
    DEB_RELEASED = 1'b0,
    DEB_PRESSED  = 1'b1
  } deb_state_e;

  // Bar index 0 is the brightest (white) bar; pixels beyond the last bar are black.
  function automatic logic [2:0] bar_colour(input logic [2:0] idx, input logic in_bars);
    return in_bars ? (3'd7 - idx) : 3'd0;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and debounce counter for an active-low key.
// One-cycle press after DEB_CYCLES stable-low cycles; re-arms after DEB_CYCLES stable-high cycles.
module key_debounce
  import vga_timing_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_lvl;

  assign key_lvl = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= DEB_RELEASED;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample at the resting level restarts the count, so short glitches never qualify.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_o = 1'b0;
    case (state_q)
      DEB_RELEASED: begin
        if (!key_lvl) begin
          if (cnt_q == CNT_LAST) begin
            state_d = DEB_PRESSED;
            press_o = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DEB_PRESSED: begin
        if (key_lvl) begin
          if (cnt_q == CNT_LAST) begin
            state_d = DEB_RELEASED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = DEB_RELEASED;
    endcase
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator; all outputs registered, one cycle behind (h,v).
// Key presses are latched and applied only at the last pixel of a frame, so frames never tear.
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = T1080_H_ACTIVE,
  parameter int H_FP       = T1080_H_FP,
  parameter int H_SYNC     = T1080_H_SYNC,
  parameter int H_BP       = T1080_H_BP,
  parameter int V_ACTIVE   = T1080_V_ACTIVE,
  parameter int V_FP       = T1080_V_FP,
  parameter int V_SYNC     = T1080_V_SYNC,
  parameter int V_BP       = T1080_V_BP,
  parameter bit HS_POL     = T1080_HS_POL,
  parameter bit VS_POL     = T1080_VS_POL,
  parameter int CW         = 1,
  parameter int CHK_LOG2   = 5,
  parameter int DEB_CYCLES = 16
) (
  input  logic                                                 CLK,
  input  logic                                                 RESET,
  input  logic                                                 KEYA,
  output logic                                                 VGA_HS,
  output logic                                                 VGA_VS,
  output logic                                                 VGA_DE,
  output logic [CW-1:0]                                        VGA_R,
  output logic [CW-1:0]                                        VGA_G,
  output logic [CW-1:0]                                        VGA_B,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]         PIX_X,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]         PIX_Y,
  output logic                                                 FRAME_START,
  output logic [1:0]                                           MODE
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BW      = H_ACTIVE / 8;
  localparam int BH      = V_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_BARS_END = HW'(8 * BW);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_BARS_END = VW'(8 * BH);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  mode_e         mode_q, mode_d;
  logic          pending_q, pending_d;
  logic          press;
  logic          h_last, frame_last;

  logic          hs_act, vs_act, de;
  logic [2:0]    h_bar, v_bar, c0, c1, colour;

  logic          hs_q, vs_q, de_q, fs_q;
  logic [CW-1:0] r_q, g_q, b_q;
  logic [HW-1:0] x_q;
  logic [VW-1:0] y_q;
  logic [1:0]    mode_out_q;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .key_n_i(KEYA),
    .press_o(press)
  );

  assign h_last     = (h_q == H_LAST);
  assign frame_last = h_last && (v_q == V_LAST);

  always_comb begin
    h_d = h_last ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_last) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Only one pending flag: extra presses in the same frame collapse into a single advance.
  always_comb begin
    pending_d = pending_q | press;
    mode_d    = mode_q;
    if (frame_last) begin
      pending_d = 1'b0;
      if (pending_q || press) begin
        mode_d = mode_e'(mode_q + 2'd1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      h_q       <= '0;
      v_q       <= '0;
      mode_q    <= MODE_VBAR;
      pending_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
    end
  end

  assign hs_act = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_act = (v_q >= VS_START) && (v_q < VS_END);
  assign de     = (h_q < H_ACT) && (v_q < V_ACT);

  // Bar index = number of bar boundaries already passed.
  always_comb begin
    h_bar = 3'd0;
    v_bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_q >= HW'(i * BW)) h_bar = 3'(i);
      if (v_q >= VW'(i * BH)) v_bar = 3'(i);
    end
  end

  always_comb begin
    c0     = bar_colour(h_bar, h_q < H_BARS_END);
    c1     = bar_colour(v_bar, v_q < V_BARS_END);
    colour = 3'd0;
    case (mode_q)
      MODE_VBAR:  colour = c0;
      MODE_HBAR:  colour = c1;
      MODE_XOR:   colour = c0 ^ c1;
      MODE_CHECK: colour = {3{h_q[CHK_LOG2] ^ v_q[CHK_LOG2]}};
      default:    colour = c0;
    endcase
    if (!de) colour = 3'd0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      de_q       <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      fs_q       <= 1'b0;
      mode_out_q <= 2'd0;
    end else begin
      hs_q       <= hs_act ? HS_POL : ~HS_POL;
      vs_q       <= vs_act ? VS_POL : ~VS_POL;
      de_q       <= de;
      r_q        <= {CW{colour[2]}};
      g_q        <= {CW{colour[1]}};
      b_q        <= {CW{colour[0]}};
      x_q        <= h_q;
      y_q        <= v_q;
      fs_q       <= (h_q == '0) && (v_q == '0);
      mode_out_q <= mode_q;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_DE      = de_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign PIX_X       = x_q;
  assign PIX_Y       = y_q;
  assign FRAME_START = fs_q;
  assign MODE        = mode_out_q;

endmodule
